// File: rtl/led_reaction_timer_if.sv
// ---------------------------------------------------------------------------
// led_reaction_timer_if
// Bundles the trial-control inputs and result outputs of the LED reaction
// timer.
//   master : drives start, random_value, button; observes results
//   slave  : the timer itself
// Signals:
//   start        begin a trial (accepted only while idle)
//   random_value delay in ms from the rng block
//   button       debounced player button, active high
//   led_on       LED drive
//   busy         trial in progress (waiting or lit)
//   result_valid one-cycle pulse when a new result is presented
//   reaction_ms  last result in ms
//   false_start  last trial ended by an early press
//   timeout      last trial ended with no press
// ---------------------------------------------------------------------------
interface led_reaction_timer_if #(
    parameter int DELAY_WIDTH = 11,
    parameter int TIME_WIDTH  = 14
);
    logic                   start;
    logic [DELAY_WIDTH-1:0] random_value;
    logic                   button;
    logic                   led_on;
    logic                   busy;
    logic                   result_valid;
    logic [TIME_WIDTH-1:0]  reaction_ms;
    logic                   false_start;
    logic                   timeout;

    modport master (
        output start, random_value, button,
        input  led_on, busy, result_valid, reaction_ms, false_start, timeout
    );

    modport slave (
        input  start, random_value, button,
        output led_on, busy, result_valid, reaction_ms, false_start, timeout
    );
endinterface

// File: rtl/led_reaction_timer.sv
// ---------------------------------------------------------------------------
// led_reaction_timer
// Waits a random delay (ms) after start, lights the LED, then measures the
// time in whole milliseconds until the button is pressed. Ends a trial with a
// valid reaction time, a false start (press before the LED) or a timeout.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset, aborts any trial
//   bus   slave side of led_reaction_timer_if (control in, results out)
// All outputs are registered; led_on/busy/result_valid are decoded from the
// registered state one cycle later, so results and result_valid line up.
// ---------------------------------------------------------------------------
module led_reaction_timer #(
    parameter int CLKS_PER_MS = 50000,
    parameter int DELAY_WIDTH = 11,
    parameter int TIME_WIDTH  = 14,
    parameter int TIMEOUT_MS  = 9999
) (
    input logic              clk,
    input logic              rst_n,
    led_reaction_timer_if.slave bus
);
    localparam int PRESC_WIDTH = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PRESC_WIDTH-1:0] PRESC_MAX    = PRESC_WIDTH'(CLKS_PER_MS - 1);
    localparam logic [PRESC_WIDTH-1:0] PRESC_ZERO   = {PRESC_WIDTH{1'b0}};
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE    = PRESC_WIDTH'(1);
    localparam logic [TIME_WIDTH-1:0]  TIMEOUT_VAL  = TIME_WIDTH'(TIMEOUT_MS);
    localparam logic [TIME_WIDTH-1:0]  TIMEOUT_LAST = TIME_WIDTH'(TIMEOUT_MS - 1);
    localparam logic [TIME_WIDTH-1:0]  TIME_ZERO    = {TIME_WIDTH{1'b0}};
    localparam logic [TIME_WIDTH-1:0]  TIME_ONE     = TIME_WIDTH'(1);
    localparam logic [DELAY_WIDTH-1:0] DELAY_ZERO   = {DELAY_WIDTH{1'b0}};
    localparam logic [DELAY_WIDTH-1:0] DELAY_ONE    = DELAY_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LIT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic [TIME_WIDTH-1:0]  elapsed_q, elapsed_d;
    // Result captured on the edge that ends the trial, published in DONE.
    logic [TIME_WIDTH-1:0]  pend_ms_q, pend_ms_d;
    logic                   pend_fs_q, pend_fs_d;
    logic                   pend_to_q, pend_to_d;
    logic [TIME_WIDTH-1:0]  reaction_ms_q, reaction_ms_d;
    logic                   false_start_q, false_start_d;
    logic                   timeout_q, timeout_d;
    logic                   led_on_q, busy_q, result_valid_q;
    logic                   wrap_s;

    assign wrap_s = (presc_q == PRESC_MAX);

    // Next-state logic for the trial FSM, counters and result registers.
    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        delay_d       = delay_q;
        elapsed_d     = elapsed_q;
        pend_ms_d     = pend_ms_q;
        pend_fs_d     = pend_fs_q;
        pend_to_d     = pend_to_q;
        reaction_ms_d = reaction_ms_q;
        false_start_d = false_start_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // A zero delay would never expire; treat it as 1 ms.
                    delay_d       = (bus.random_value == DELAY_ZERO) ? DELAY_ONE : bus.random_value;
                    presc_d       = PRESC_ZERO;
                    elapsed_d     = TIME_ZERO;
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                    state_d       = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.button) begin
                    // Early press wins even on the edge the delay expires.
                    pend_ms_d = TIME_ZERO;
                    pend_fs_d = 1'b1;
                    pend_to_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (wrap_s) begin
                    presc_d = PRESC_ZERO;
                    if (delay_q == DELAY_ONE) begin
                        state_d = ST_LIT;
                    end else begin
                        delay_d = delay_q - DELAY_ONE;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            ST_LIT: begin
                if (bus.button) begin
                    // Reports completed milliseconds, before any same-edge increment.
                    pend_ms_d = elapsed_q;
                    pend_fs_d = 1'b0;
                    pend_to_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (wrap_s) begin
                    presc_d = PRESC_ZERO;
                    if (elapsed_q == TIMEOUT_LAST) begin
                        elapsed_d = TIMEOUT_VAL;
                        pend_ms_d = TIMEOUT_VAL;
                        pend_fs_d = 1'b0;
                        pend_to_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (elapsed_q != TIMEOUT_VAL) begin
                        elapsed_d = elapsed_q + TIME_ONE;
                    end else begin
                        elapsed_d = elapsed_q;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            ST_DONE: begin
                reaction_ms_d = pend_ms_q;
                false_start_d = pend_fs_q;
                timeout_d     = pend_to_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any trial at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            presc_q        <= PRESC_ZERO;
            delay_q        <= DELAY_ZERO;
            elapsed_q      <= TIME_ZERO;
            pend_ms_q      <= TIME_ZERO;
            pend_fs_q      <= 1'b0;
            pend_to_q      <= 1'b0;
            reaction_ms_q  <= TIME_ZERO;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
            led_on_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            delay_q        <= delay_d;
            elapsed_q      <= elapsed_d;
            pend_ms_q      <= pend_ms_d;
            pend_fs_q      <= pend_fs_d;
            pend_to_q      <= pend_to_d;
            reaction_ms_q  <= reaction_ms_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
            led_on_q       <= (state_q == ST_LIT);
            busy_q         <= (state_q == ST_WAIT) || (state_q == ST_LIT);
            result_valid_q <= (state_q == ST_DONE);
        end
    end

    assign bus.led_on       = led_on_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.reaction_ms  = reaction_ms_q;
    assign bus.false_start  = false_start_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_led_reaction_timer.sv
// ---------------------------------------------------------------------------
// tb_led_reaction_timer
// Table-driven trials (CLKS_PER_MS=4, TIMEOUT_MS=5) with a result scoreboard,
// plus hand-written reset sequences. Edge numbers count rising edges after
// the edge that accepts start (that edge is edge 0).
// ---------------------------------------------------------------------------
module tb_led_reaction_timer;
    localparam int CPM = 4;
    localparam int DW  = 11;
    localparam int TW  = 14;
    localparam int TO  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_reaction_timer_if #(.DELAY_WIDTH(DW), .TIME_WIDTH(TW)) bus();

    led_reaction_timer #(
        .CLKS_PER_MS(CPM), .DELAY_WIDTH(DW), .TIME_WIDTH(TW), .TIMEOUT_MS(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int rv;          // random_value
        int p_from;      // first edge with button high (-1: none)
        int p_to;        // last edge with button high
        int extra_start; // edge with a stray start during the trial (0: none)
        int exp_ms;
        int exp_fs;
        int exp_to;
        int exp_valid;   // edge after which result_valid is seen
        int exp_led;     // edge after which led_on first reads 1 (0: never)
        int exp_led_cyc; // cycles led_on is high
    } vec_t;

    typedef struct {
        int ms;
        int fs;
        int to;
        int valid_edge;
    } res_t;

    vec_t vecs[9];
    res_t sb_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_trial(input vec_t v, input int prev_ms);
        int led_edge = 0;
        int led_cyc = 0;
        bit got = 1'b0;
        res_t r;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.random_value = DW'(v.rv);
        bus.button       = (v.p_from <= 0) && (v.p_to >= 0);
        sb_q.push_back('{v.exp_ms, v.exp_fs, v.exp_to, v.exp_valid});
        for (int e = 1; e <= 80; e++) begin
            @(negedge clk);
            if (e - 1 == 0) begin
                check("busy_after_start_edge", 32'(bus.busy), 32'd0);
                check("fs_cleared_on_start", 32'(bus.false_start), 32'd0);
                check("to_cleared_on_start", 32'(bus.timeout), 32'd0);
                check("ms_held_on_start", 32'(bus.reaction_ms), 32'(prev_ms));
            end
            if (e - 1 == 1) begin
                check("busy_next_edge", 32'(bus.busy), 32'd1);
            end
            if (bus.led_on) begin
                led_cyc++;
                if (led_edge == 0) led_edge = e - 1;
            end
            if (bus.result_valid) begin
                got = 1'b1;
                check("led_low_at_result", 32'(bus.led_on), 32'd0);
                check("busy_low_at_result", 32'(bus.busy), 32'd0);
                if (sb_q.size() == 0) begin
                    check("scoreboard_nonempty", 32'd0, 32'd1);
                end else begin
                    r = sb_q.pop_front();
                    check("reaction_ms", 32'(bus.reaction_ms), 32'(r.ms));
                    check("false_start", 32'(bus.false_start), 32'(r.fs));
                    check("timeout", 32'(bus.timeout), 32'(r.to));
                    check("result_edge", 32'(e - 1), 32'(r.valid_edge));
                end
                break;
            end
            bus.start  = (e == v.extra_start);
            bus.button = (e >= v.p_from) && (e <= v.p_to);
        end
        bus.start  = 1'b0;
        bus.button = 1'b0;
        if (!got) begin
            check("result_within_budget", 32'd0, 32'd1);
            sb_q.delete();
        end
        check("led_rise_edge", 32'(led_edge), 32'(v.exp_led));
        check("led_high_cycles", 32'(led_cyc), 32'(v.exp_led_cyc));
        @(negedge clk);
        check("result_valid_one_cycle", 32'(bus.result_valid), 32'd0);
    endtask

    initial begin
        int prev_ms;
        int valid_cnt;
        //           rv  pf  pt  xs  ms fs to vld led cyc
        vecs[0] = '{3, 23, 23, 0, 2, 0, 0, 24, 13, 11};  // press 10 cycles after LED
        vecs[1] = '{3,  5,  5, 0, 0, 1, 0,  6,  0,  0};  // press during delay
        vecs[2] = '{2, -1, -1, 0, 5, 0, 1, 29,  9, 20};  // no press: timeout
        vecs[3] = '{0,  5,  5, 2, 0, 0, 0,  6,  5,  1};  // zero delay clamped, stray start
        vecs[4] = '{1,  4,  4, 0, 0, 1, 0,  5,  0,  0};  // press on delay-expiry edge
        vecs[5] = '{1, 24, 24, 0, 4, 0, 0, 25,  5, 20};  // press on timeout edge wins
        vecs[6] = '{1, 25, 25, 0, 5, 0, 1, 25,  5, 20};  // press one edge too late
        vecs[7] = '{2, 13, 13, 0, 1, 0, 0, 14,  9,  5};  // one full ms elapsed
        vecs[8] = '{3,  0,  1, 0, 0, 1, 0,  2,  0,  0};  // button held from before start

        bus.start = 1'b0;
        bus.random_value = '0;
        bus.button = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led_on", 32'(bus.led_on), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_reaction_ms", 32'(bus.reaction_ms), 32'd0);
        check("rst_false_start", 32'(bus.false_start), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        prev_ms = 0;
        for (int i = 0; i < 9; i++) begin
            run_trial(vecs[i], prev_ms);
            prev_ms = vecs[i].exp_ms;
        end

        // Reset three cycles into LIT aborts the trial with no result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.random_value = DW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check("lit_before_reset", 32'(bus.led_on), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_led_on", 32'(bus.led_on), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_ms", 32'(bus.reaction_ms), 32'd0);
        check("async_rst_fs", 32'(bus.false_start), 32'd0);
        check("async_rst_to", 32'(bus.timeout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        valid_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.result_valid) valid_cnt++;
        end
        check("no_result_after_abort", 32'(valid_cnt), 32'd0);

        // A fresh trial after the abort behaves like the first one.
        run_trial(vecs[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/led_reaction_timer.md
Name: led_reaction_timer

Overview:
- Consumes `random_value` from the upstream `rng` block (range OFFSET..MAX_VALUE, default 200..1223) as a delay in milliseconds.
- On `start`, it waits that delay, lights the LED, and then measures the reaction time in milliseconds until the button is pressed.
- Reports the result as one of three outcomes: a valid reaction time, a false start, or a timeout.
- Sits between `rng` and the LED/display drivers in the LED module.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond (50 MHz clk).
- DELAY_WIDTH, 11, width of `random_value`; matches `rng` output.
- TIME_WIDTH, 14, width of `reaction_ms`.
- TIMEOUT_MS, 9999, reaction window in ms before timeout; must be less than 2^TIME_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a trial; sampled only in IDLE.
- random_value  input  DELAY_WIDTH  delay in ms from `rng`; latched on accepted start.
- button  input  1  player button, already synchronised/debounced, active high.
- led_on  output  1  LED drive; high only in LIT.
- busy  output  1  high in WAIT and LIT.
- result_valid  output  1  single-cycle pulse when a result is written.
- reaction_ms  output  TIME_WIDTH  last result in ms; held until the next result.
- false_start  output  1  last trial ended by a press during the delay; held.
- timeout  output  1  last trial ended without a press; held.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; prescaler, delay counter and elapsed counter 0. Reset mid-trial aborts immediately; no result_valid is produced.
- States are IDLE, WAIT, LIT, DONE.
- IDLE:
  - On start=1 at an edge: latch `random_value` into the delay counter; a value of 0 is clamped to 1.
  - Clear prescaler and elapsed counter; go to WAIT.
  - Clear false_start and timeout on this same edge; reaction_ms holds its old value.
  - start in any other state is ignored.
- WAIT:
  - Prescaler counts 0..CLKS_PER_MS-1 and wraps; on each wrap the delay counter decrements.
  - When a wrap occurs with delay counter = 1, go to LIT and clear the prescaler.
  - led_on rises exactly D*CLKS_PER_MS + 1 edges after the edge that accepted start, where D is the clamped latched value.
  - button=1 at any WAIT edge (including the edge on which the delay expires, and a button held from before start):
    - go to DONE with false_start=1 and reaction_ms=0;
    - the LED never lights.
- LIT:
  - Prescaler runs; on each wrap the elapsed counter increments, so it counts completed milliseconds (floor).
  - button=1: go to DONE with reaction_ms=elapsed (value before any increment on that same edge).
  - Elapsed reaching TIMEOUT_MS (on the wrap edge, with no press on that edge): go to DONE with timeout=1 and reaction_ms=TIMEOUT_MS.
  - A press on that same edge takes priority and is recorded with reaction_ms=TIMEOUT_MS-1.
- DONE:
  - Lasts one cycle; result_valid=1, led_on=0, busy=0.
  - Go to IDLE next edge.
  - A start asserted during DONE is not accepted; it must be presented in IDLE.
- Outputs are registered; led_on, busy and result_valid are decoded from the registered state.
- Width rules:
  - Elapsed counter saturates at TIMEOUT_MS and never wraps.
  - Prescaler width is clog2(CLKS_PER_MS).
  - Delay counter width is DELAY_WIDTH.

Test Plan (CLKS_PER_MS=4, TIMEOUT_MS=5 unless noted):
- rst_n low then high; start pulse with random_value=3 → busy rises next edge; led_on rises exactly 13 edges after the start edge; no result yet.
- From the previous scenario, assert button 10 cycles after led_on rises → one-cycle result_valid, reaction_ms=2, false_start=0, timeout=0, led_on low, then IDLE.
- random_value=3, button pulse 5 cycles after start → false_start=1, reaction_ms=0, result_valid pulse, led_on never high.
- random_value=2, no button → led_on high for 20 cycles, then timeout=1, reaction_ms=5, result_valid pulse.
- random_value=0 → led_on rises 5 edges after start (clamped to 1 ms); a second start during WAIT is ignored (no timing change).
- Reset asserted 3 cycles into LIT → led_on, busy and all flags 0 immediately (asynchronous); no result_valid; a fresh start then behaves as in the first scenario.
